// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline hazard logic:
//                register-file address type, forwarding-select encoding,
//                hazard FSM state encoding and the NOP opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Register-file address width; address 0 is the hardwired zero register.
    localparam int c_RF_ADRS_W = 4;

    typedef logic [c_RF_ADRS_W-1:0] t_RFadrs;

    // Operand source selected for an EX operand.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } t_fwd_sel;

    // Hazard controller states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        FLUSH   = 2'd2
    } t_hz_state;

    // ALU opcode loaded into ID/EX when a bubble is injected.
    localparam logic [5:0] c_NOP_OPCODE = 6'h00;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/fwd_unit.sv
// ============================================================================
//  Module      : fwd_unit
//  Description : Combinational forward/hazard compare for one ID source.
//                Picks the newest producer of the source register (EX before
//                MEM) and flags a load-use hazard when the EX producer is a
//                load whose data is not yet available.
//  Ports       : i_src/i_use          - ID source address and its use flag
//                i_ex_*               - EX-stage producer information
//                i_mem_*              - MEM-stage producer information
//                o_fwd_sel            - forwarding select for this source
//                o_load_use           - load-use hazard on this source
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_unit
    import pipe_pkg::*;
#(
    parameter int RF_ADRS_W = c_RF_ADRS_W
) (
    input  logic [RF_ADRS_W-1:0] i_src,
    input  logic                 i_use,
    input  logic [RF_ADRS_W-1:0] i_ex_dst,
    input  logic                 i_ex_wr_en,
    input  logic                 i_ex_is_load,
    input  logic [RF_ADRS_W-1:0] i_mem_dst,
    input  logic                 i_mem_wr_en,
    output t_fwd_sel             o_fwd_sel,
    output logic                 o_load_use
);

    logic w_src_nz;
    logic w_ex_hit;
    logic w_mem_hit;

    // Register 0 always reads zero, so it is never a dependency.
    assign w_src_nz  = (i_src != '0);
    assign w_ex_hit  = w_src_nz && i_ex_wr_en  && (i_ex_dst  == i_src);
    assign w_mem_hit = w_src_nz && i_mem_wr_en && (i_mem_dst == i_src);

    always_comb begin
        o_fwd_sel = FWD_RF;
        // A load in EX has no data yet, so it cannot be an EX forward source.
        if (w_ex_hit && !i_ex_is_load) begin
            o_fwd_sel = FWD_EX;
        end else if (w_mem_hit) begin
            o_fwd_sel = FWD_MEM;
        end
    end

    assign o_load_use = i_use && w_ex_hit && i_ex_is_load;

endmodule : fwd_unit

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard and sequencing controller for the ID->EX register.
//                Stalls the front end for load-use and multi-cycle hazards,
//                injects bubbles after a taken branch and registers the
//                operand forwarding selects alongside the ID/EX contents.
//  Ports       : clock, rst_n (synchronous, active low)
//                id_src1/2, id_use1/2   - ID-stage operand sources
//                ex_dst, ex_wr_en, ex_is_load, ex_mc_start, ex_br_taken
//                mem_dst, mem_wr_en
//                stall_fe, bubble_ex, hold_ex, flush_id  - pipeline controls
//                fwd_sel1/2             - registered forwarding selects
//                busy                   - controller not in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RF_ADRS_W = c_RF_ADRS_W,
    parameter int MC_LAT    = 3,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [RF_ADRS_W-1:0] id_src1,
    input  logic [RF_ADRS_W-1:0] id_src2,
    input  logic                 id_use1,
    input  logic                 id_use2,
    input  logic [RF_ADRS_W-1:0] ex_dst,
    input  logic                 ex_wr_en,
    input  logic                 ex_is_load,
    input  logic                 ex_mc_start,
    input  logic                 ex_br_taken,
    input  logic [RF_ADRS_W-1:0] mem_dst,
    input  logic                 mem_wr_en,
    output logic                 stall_fe,
    output logic                 bubble_ex,
    output logic                 hold_ex,
    output logic                 flush_id,
    output logic [1:0]           fwd_sel1,
    output logic [1:0]           fwd_sel2,
    output logic                 busy
);

    // Counter preloads; the first hazard cycle is spent in RUN, hence the offsets.
    localparam logic [3:0] c_FLUSH_INIT = 4'(FLUSH_CYC - 2);
    localparam logic [3:0] c_MC_INIT    = 4'(MC_LAT - 3);

    t_hz_state r_state;
    t_hz_state w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    t_fwd_sel  r_fwd_sel1;
    t_fwd_sel  r_fwd_sel2;

    t_fwd_sel  w_fwd1;
    t_fwd_sel  w_fwd2;
    logic      w_lu1;
    logic      w_lu2;
    logic      w_load_use;

    logic      w_stall_fe;
    logic      w_bubble_ex;
    logic      w_hold_ex;
    logic      w_flush_id;

    fwd_unit #(.RF_ADRS_W(RF_ADRS_W)) u_fwd1 (
        .i_src        (id_src1),
        .i_use        (id_use1),
        .i_ex_dst     (ex_dst),
        .i_ex_wr_en   (ex_wr_en),
        .i_ex_is_load (ex_is_load),
        .i_mem_dst    (mem_dst),
        .i_mem_wr_en  (mem_wr_en),
        .o_fwd_sel    (w_fwd1),
        .o_load_use   (w_lu1)
    );

    fwd_unit #(.RF_ADRS_W(RF_ADRS_W)) u_fwd2 (
        .i_src        (id_src2),
        .i_use        (id_use2),
        .i_ex_dst     (ex_dst),
        .i_ex_wr_en   (ex_wr_en),
        .i_ex_is_load (ex_is_load),
        .i_mem_dst    (mem_dst),
        .i_mem_wr_en  (mem_wr_en),
        .o_fwd_sel    (w_fwd2),
        .o_load_use   (w_lu2)
    );

    assign w_load_use = w_lu1 || w_lu2;

    // Next-state and control decode. Branch beats multi-cycle start, which
    // beats load-use; branch/mc_start are only honoured in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_fe  = 1'b0;
        w_bubble_ex = 1'b0;
        w_hold_ex   = 1'b0;
        w_flush_id  = 1'b0;

        case (r_state)
            RUN: begin
                if (ex_br_taken) begin
                    w_flush_id  = 1'b1;
                    w_bubble_ex = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        w_state_nxt = FLUSH;
                        w_cnt_nxt   = c_FLUSH_INIT;
                    end
                end else if (ex_mc_start) begin
                    w_stall_fe = 1'b1;
                    w_hold_ex  = 1'b1;
                    if (MC_LAT > 2) begin
                        w_state_nxt = MC_BUSY;
                        w_cnt_nxt   = c_MC_INIT;
                    end
                end else if (w_load_use) begin
                    w_stall_fe  = 1'b1;
                    w_bubble_ex = 1'b1;
                end
            end
            MC_BUSY: begin
                w_stall_fe = 1'b1;
                w_hold_ex  = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            FLUSH: begin
                w_bubble_ex = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_cnt      <= 4'd0;
            r_fwd_sel1 <= FWD_RF;
            r_fwd_sel2 <= FWD_RF;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Selects travel with the ID/EX contents: frozen on hold,
            // neutral when a bubble replaces the instruction.
            if (!w_hold_ex) begin
                r_fwd_sel1 <= w_bubble_ex ? FWD_RF : w_fwd1;
                r_fwd_sel2 <= w_bubble_ex ? FWD_RF : w_fwd2;
            end
        end
    end

    // Controls are forced quiet while reset is asserted.
    assign stall_fe  = rst_n && w_stall_fe;
    assign bubble_ex = rst_n && w_bubble_ex;
    assign hold_ex   = rst_n && w_hold_ex;
    assign flush_id  = rst_n && w_flush_id;
    assign busy      = rst_n && (r_state != RUN);
    assign fwd_sel1  = r_fwd_sel1;
    assign fwd_sel2  = r_fwd_sel2;

endmodule : pipe_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl with
//                MC_LAT=3, FLUSH_CYC=2. Control outputs are compared as
//                {stall_fe, bubble_ex, hold_ex, flush_id, busy}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [3:0] id_src1, id_src2, ex_dst, mem_dst;
    logic       id_use1, id_use2, ex_wr_en, ex_is_load, ex_mc_start, ex_br_taken, mem_wr_en;
    logic       stall_fe, bubble_ex, hold_ex, flush_id, busy;
    logic [1:0] fwd_sel1, fwd_sel2;

    int vectors    = 0;
    int miscompares = 0;

    pipe_hazard_ctrl #(.RF_ADRS_W(4), .MC_LAT(3), .FLUSH_CYC(2)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .ex_dst      (ex_dst),
        .ex_wr_en    (ex_wr_en),
        .ex_is_load  (ex_is_load),
        .ex_mc_start (ex_mc_start),
        .ex_br_taken (ex_br_taken),
        .mem_dst     (mem_dst),
        .mem_wr_en   (mem_wr_en),
        .stall_fe    (stall_fe),
        .bubble_ex   (bubble_ex),
        .hold_ex     (hold_ex),
        .flush_id    (flush_id),
        .fwd_sel1    (fwd_sel1),
        .fwd_sel2    (fwd_sel2),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // {stall_fe, bubble_ex, hold_ex, flush_id, busy}
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {stall_fe, bubble_ex, hold_ex, flush_id, busy}, exp);
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] exp1, input logic [1:0] exp2);
        check(tag, {1'b0, fwd_sel1, fwd_sel2}, {1'b0, exp1, exp2});
    endtask

    task automatic idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_dst = 4'd0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
        ex_mc_start = 1'b0; ex_br_taken = 1'b0;
        mem_dst = 4'd0; mem_wr_en = 1'b0;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // Reset while a branch is requested: controls must stay quiet.
        ex_br_taken = 1'b1;
        next();
        mid();
        check_ctl("reset_ctl", 5'b00000);
        check_fwd("reset_fwd", 2'd0, 2'd0);
        next();
        rst_n = 1'b1;
        idle();
        mid();
        check_ctl("post_reset_idle", 5'b00000);
        next();

        // 1. ALU result in EX forwarded to src1.
        ex_dst = 4'd3; ex_wr_en = 1'b1; id_src1 = 4'd3; id_use1 = 1'b1;
        mid();
        check_ctl("ex_fwd_nostall", 5'b00000);
        next();
        idle();
        mid();
        check_fwd("ex_fwd_sel", 2'd1, 2'd0);
        // EX and MEM both write r8: EX is newer and wins; r9 only in MEM.
        ex_dst = 4'd8; ex_wr_en = 1'b1; mem_dst = 4'd8; mem_wr_en = 1'b1;
        id_src1 = 4'd8; id_src2 = 4'd8; id_use1 = 1'b1; id_use2 = 1'b1;
        next();
        idle();
        mid();
        check_fwd("ex_over_mem", 2'd1, 2'd1);
        mem_dst = 4'd9; mem_wr_en = 1'b1; id_src2 = 4'd9;
        next();
        idle();
        mid();
        check_fwd("mem_fwd_sel", 2'd0, 2'd2);
        next();

        // 2. Load r5 in EX, ID uses r5 as src2; MEM also matches but the bubble wins.
        ex_dst = 4'd5; ex_wr_en = 1'b1; ex_is_load = 1'b1;
        id_src2 = 4'd5; id_use2 = 1'b1; mem_dst = 4'd5; mem_wr_en = 1'b1;
        mid();
        check_ctl("load_use_stall", 5'b11000);
        next();
        idle();
        id_src2 = 4'd5; id_use2 = 1'b1; mem_dst = 4'd5; mem_wr_en = 1'b1;
        mid();
        check_ctl("load_use_1cyc", 5'b00000);
        check_fwd("bubble_loads_rf", 2'd0, 2'd0);
        next();
        idle();
        mid();
        check_fwd("load_mem_fwd", 2'd0, 2'd2);
        // Load match on a source the instruction does not read: no stall.
        ex_dst = 4'd6; ex_wr_en = 1'b1; ex_is_load = 1'b1; id_src1 = 4'd6;
        mid();
        check_ctl("load_unused_src", 5'b00000);
        next();
        idle();
        next();

        // 3. Multi-cycle op; EX match on src1 must not reach the held selects.
        ex_mc_start = 1'b1; ex_dst = 4'd7; ex_wr_en = 1'b1; id_src1 = 4'd7; id_use1 = 1'b1;
        mid();
        check_ctl("mc_cycle0", 5'b10100);
        next();
        idle();
        ex_dst = 4'd7; ex_wr_en = 1'b1; id_src1 = 4'd7; id_use1 = 1'b1;
        mid();
        check_ctl("mc_cycle1", 5'b10101);
        check_fwd("mc_hold_fwd", 2'd0, 2'd0);
        next();
        idle();
        mid();
        check_ctl("mc_done", 5'b00000);
        next();

        // 4. Taken branch, FLUSH_CYC=2.
        ex_br_taken = 1'b1;
        mid();
        check_ctl("br_cycle0", 5'b01010);
        next();
        idle();
        mid();
        check_ctl("br_cycle1", 5'b01001);
        next();
        mid();
        check_ctl("br_done", 5'b00000);
        next();

        // 5. Branch together with load-use: branch wins, no stall.
        ex_br_taken = 1'b1; ex_dst = 4'd6; ex_wr_en = 1'b1; ex_is_load = 1'b1;
        id_src1 = 4'd6; id_use1 = 1'b1;
        mid();
        check_ctl("br_vs_loaduse", 5'b01010);
        next();
        idle();
        next();

        // Load-use together with mc_start: hold wins, no bubble.
        ex_mc_start = 1'b1; ex_dst = 4'd2; ex_wr_en = 1'b1; ex_is_load = 1'b1;
        id_src2 = 4'd2; id_use2 = 1'b1;
        mid();
        check_ctl("mc_vs_loaduse", 5'b10100);
        next();
        idle();
        next();

        // Register 0 never forwards nor causes a load-use stall.
        ex_dst = 4'd0; ex_wr_en = 1'b1; ex_is_load = 1'b1; id_src1 = 4'd0; id_use1 = 1'b1;
        mem_dst = 4'd0; mem_wr_en = 1'b1; id_src2 = 4'd0; id_use2 = 1'b1;
        mid();
        check_ctl("r0_no_stall", 5'b00000);
        next();
        idle();
        ex_dst = 4'd0; ex_wr_en = 1'b1; id_src1 = 4'd0; id_use1 = 1'b1;
        mem_dst = 4'd0; mem_wr_en = 1'b1;
        mid();
        check_fwd("r0_no_fwd_a", 2'd0, 2'd0);
        next();
        idle();
        mid();
        check_fwd("r0_no_fwd_b", 2'd0, 2'd0);

        // 6. Reset during MC_BUSY with non-RF selects latched.
        ex_dst = 4'd9; ex_wr_en = 1'b1; id_src1 = 4'd9; id_use1 = 1'b1;
        next();
        idle();
        ex_mc_start = 1'b1;
        mid();
        check_fwd("pre_reset_fwd", 2'd1, 2'd0);
        next();
        idle();
        rst_n = 1'b0;
        mid();
        check_ctl("reset_in_mc", 5'b00000);
        next();
        rst_n = 1'b1;
        mid();
        check_ctl("after_reset_mc", 5'b00000);
        check_fwd("after_reset_fwd", 2'd0, 2'd0);
        next();
        mid();
        check_ctl("no_residual", 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pipe_hazard_ctrl

`default_nettype wire
